// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and sizing helpers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit-counter width: clog2(n), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Configuration is legal when DIGIT is in 1..WIDTH and divides WIDTH.
    function automatic bit cfg_legal(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit combinational ripple adder built from full-adder cells.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit A+B+cin, DIGIT bits per clock, LSD first.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds i_SUB).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_START,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    input  logic             i_CARRY_IN,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_SUB,
`endif
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [WIDTH-1:0] o_SUM,
    output logic             o_CARRY
);

    localparam bit CFG_OK = cfg_legal(WIDTH, DIGIT);
    // An illegal configuration degenerates to N=1 rather than a bogus count.
    localparam int N  = CFG_OK ? (WIDTH / DIGIT) : 1;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             accept;
    logic             last_digit;
    logic [WIDTH-1:0] b_capture;
    logic             c_capture;

    assign accept     = i_START && ((state == IDLE) || (state == DONE));
    assign last_digit = (state == RUN) && (cnt == LAST);

`ifdef SERIAL_ADDER_SUB_EN
    assign b_capture = i_SUB ? ~i_OPERAND_B : i_OPERAND_B;
    assign c_capture = i_SUB ? 1'b1 : i_CARRY_IN;
`else
    assign b_capture = i_OPERAND_B;
    assign c_capture = i_CARRY_IN;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .cin  (carry_r),
        .sum  (dsum),
        .cout (dcout)
    );

    // New digit enters at the top; with a single digit it is the whole sum.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign sum_next = dsum;
    end else begin : g_multi_digit
        assign sum_next = {dsum, sum_sr[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic: DONE lasts one cycle and may chain straight into RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, digit-serial shifting and result registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            o_SUM   <= '0;
            o_CARRY <= 1'b0;
        end else if (accept) begin
            a_sr    <= i_OPERAND_A;
            b_sr    <= b_capture;
            carry_r <= c_capture;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> DIGIT;
            b_sr    <= b_sr >> DIGIT;
            sum_sr  <= sum_next;
            carry_r <= dcout;
            cnt     <= cnt + 1'b1;
            if (last_digit) begin
                o_SUM   <= sum_next;
                o_CARRY <= dcout;
            end
        end
    end

    assign o_BUSY = (state == RUN);
    assign o_DONE = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=16, DIGIT=4).
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        cin;
    logic        sub;
    logic        busy, done, carry;
    logic [15:0] sum;

    int checks   = 0;
    int failures = 0;
    int lat, busy_cnt, hold_bad, done_cnt;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .i_CLK       (clk),
        .i_RESET     (rst),
        .i_START     (start),
        .i_OPERAND_A (op_a),
        .i_OPERAND_B (op_b),
        .i_CARRY_IN  (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .i_SUB       (sub),
`endif
        .o_BUSY      (busy),
        .o_DONE      (done),
        .o_SUM       (sum),
        .o_CARRY     (carry)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; afterwards the DUT is in RUN.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic s);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = 16'hDEAD;
        op_b  = 16'hBEEF;
        cin   = 1'b0;
    endtask

    // Called one cycle after the accepting edge; bounded wait for o_DONE.
    task automatic wait_done(input logic [15:0] prev, output int l,
                             output int b, output int hb);
        l  = 1;
        b  = 0;
        hb = 0;
        while (!done && l < 20) begin
            if (busy) b++;
            if (sum !== prev) hb = 1;
            step();
            l++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        step();
        step();
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_sum",   32'(sum),   32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        rst = 1'b0;
        step();

        // Basic add: latency and busy length.
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_done(16'h0000, lat, busy_cnt, hold_bad);
        chk("basic_latency", 32'(lat),      32'd5);
        chk("basic_busy",    32'(busy_cnt), 32'd4);
        chk("basic_hold",    32'(hold_bad), 32'd0);
        chk("basic_sum",     32'(sum),      32'h2345);
        chk("basic_carry",   32'(carry),    32'd0);
        step();
        chk("idle_done",     32'(done),     32'd0);
        chk("idle_busy",     32'(busy),     32'd0);
        chk("idle_sum_hold", 32'(sum),      32'h2345);

        // Carry-in ripples through every digit.
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_done(16'h2345, lat, busy_cnt, hold_bad);
        chk("cin_ripple_sum",   32'(sum),   32'h0000);
        chk("cin_ripple_carry", 32'(carry), 32'd1);
        step();

        // Start pulse during RUN is ignored; exactly one done.
        start_op(16'h8000, 16'h8001, 1'b0, 1'b0);
        op_a  = 16'h0001;
        op_b  = 16'h0001;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                done_cnt++;
                chk("ignore_sum",   32'(sum),   32'h0001);
                chk("ignore_carry", 32'(carry), 32'd1);
            end
            step();
        end
        chk("ignore_done_count", 32'(done_cnt), 32'd1);

        // Carry generated in the low digit propagates to the top.
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(16'h0001, lat, busy_cnt, hold_bad);
        chk("ripple_sum",   32'(sum),   32'h0000);
        chk("ripple_carry", 32'(carry), 32'd1);
        step();

        // Reset in the second RUN cycle abandons the operation.
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_done",  32'(done),  32'd0);
        chk("midrst_sum",   32'(sum),   32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            step();
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        // Back-to-back: start held in DONE re-enters RUN without IDLE.
        start_op(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done(16'h0000, lat, busy_cnt, hold_bad);
        chk("b2b_first_sum", 32'(sum), 32'h0007);
        op_a  = 16'h00FF;
        op_b  = 16'h0F01;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy_now", 32'(busy), 32'd1);
        wait_done(16'h0007, lat, busy_cnt, hold_bad);
        chk("b2b_latency", 32'(lat),      32'd5);
        chk("b2b_hold",    32'(hold_bad), 32'd0);
        chk("b2b_sum",     32'(sum),      32'h1000);
        chk("b2b_carry",   32'(carry),    32'd0);
        step();

`ifdef SERIAL_ADDER_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_done(16'h1000, lat, busy_cnt, hold_bad);
        chk("sub_neg_sum",   32'(sum),   32'hFFFE);
        chk("sub_neg_carry", 32'(carry), 32'd0);
        step();
        start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
        wait_done(16'hFFFE, lat, busy_cnt, hold_bad);
        chk("sub_pos_sum",   32'(sum),   32'h0002);
        chk("sub_pos_carry", 32'(carry), 32'd1);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
